// File: rtl/fifo_burst_reader.sv
// Burst reader that drains a non-fallthrough synchronous FIFO into a
// valid/ready stream. Bursts start on a FIFO threshold, a flush request or an
// idle-with-data timeout, and each burst ends with a single out_last word.
module fifo_burst_reader #(
   parameter int pDATA_WIDTH = 8,
   parameter int pBURST_LEN  = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic                   flush_req,
   input  logic [15:0]            timeout_cycles,
   input  logic                   fifo_empty,
   input  logic                   fifo_almost_empty,
   input  logic                   fifo_full_threshold,
   input  logic [pDATA_WIDTH-1:0] fifo_rdata,
   output logic                   fifo_ren,
   output logic [pDATA_WIDTH-1:0] out_data,
   output logic                   out_valid,
   output logic                   out_last,
   input  logic                   out_ready,
   output logic                   busy,
   output logic [15:0]            burst_count
);

   localparam logic [7:0] BURST_LEN_C = 8'(pBURST_LEN);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FULL  = 2'd1,
      ST_PART  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  words_left_q, words_left_d;
   logic [15:0] tmo_cnt_q, tmo_cnt_d;
   logic        flush_pend_q, flush_pend_d;
   logic        out_valid_q, out_valid_d;
   logic        out_last_q, out_last_d;
   logic        busy_q, busy_d;
   logic [15:0] burst_cnt_q, burst_cnt_d;

   logic        in_burst_s;
   logic        ren_s;
   logic        last_at_read_s;
   logic        tmo_qualify_s;
   logic        tmo_expire_s;
   logic        pend_s;

   // The read data port of the FIFO is already registered, so it feeds the stream directly.
   assign out_data    = fifo_rdata;
   assign out_valid   = out_valid_q;
   assign out_last    = out_last_q;
   assign busy        = busy_q;
   assign burst_count = burst_cnt_q;
   assign fifo_ren    = ren_s;

   // Read strobe, end-of-burst detection and timeout qualification.
   always_comb begin
      in_burst_s     = (state_q == ST_FULL) || (state_q == ST_PART);
      ren_s          = in_burst_s && !fifo_empty && (words_left_q != 8'd0) &&
                       (!out_valid_q || out_ready);
      last_at_read_s = (words_left_q == 8'd1) ||
                       ((state_q == ST_PART) && fifo_almost_empty);
      tmo_qualify_s  = (state_q == ST_IDLE) && enable && !fifo_empty;
      tmo_expire_s   = tmo_qualify_s && (timeout_cycles != 16'd0) &&
                       (tmo_cnt_q == timeout_cycles);
      // A flush pulse counts as pending in the same cycle it arrives.
      pend_s         = flush_pend_q || flush_req;
   end

   // Next-state, burst bookkeeping and registered stream controls.
   always_comb begin
      state_d      = state_q;
      words_left_d = words_left_q;
      tmo_cnt_d    = 16'd0;
      burst_cnt_d  = burst_cnt_q;
      // A flush seen with nothing to drain in IDLE is simply dropped.
      flush_pend_d = ((state_q == ST_IDLE) && fifo_empty) ? 1'b0 : pend_s;
      out_valid_d  = out_valid_q;
      out_last_d   = out_last_q;

      case (state_q)
         ST_IDLE: begin
            if (tmo_qualify_s) begin
               tmo_cnt_d = tmo_cnt_q + 16'd1;
            end else begin
               tmo_cnt_d = 16'd0;
            end
            if (enable && fifo_full_threshold) begin
               state_d      = ST_FULL;
               words_left_d = BURST_LEN_C;
            end else if (enable && pend_s && !fifo_empty) begin
               state_d      = ST_PART;
               words_left_d = BURST_LEN_C;
               flush_pend_d = 1'b0;
            end else if (tmo_expire_s) begin
               state_d      = ST_PART;
               words_left_d = BURST_LEN_C;
               flush_pend_d = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FULL, ST_PART: begin
            if (ren_s) begin
               words_left_d = words_left_q - 8'd1;
               if (last_at_read_s) begin
                  state_d = ST_DRAIN;
               end else begin
                  state_d = state_q;
               end
            end else begin
               // FIFO empty or downstream stalled: wait, never cut the burst short.
               state_d = state_q;
            end
         end
         ST_DRAIN: begin
            if (out_valid_q && out_ready && out_last_q) begin
               state_d     = ST_IDLE;
               burst_cnt_d = burst_cnt_q + 16'd1;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A word read this cycle becomes valid next cycle; otherwise an accepted word retires.
      if (ren_s) begin
         out_valid_d = 1'b1;
         out_last_d  = last_at_read_s;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
         out_last_d  = out_last_q;
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; reset abandons any burst in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         words_left_q <= 8'd0;
         tmo_cnt_q    <= 16'd0;
         flush_pend_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         busy_q       <= 1'b0;
         burst_cnt_q  <= 16'd0;
      end else begin
         state_q      <= state_d;
         words_left_q <= words_left_d;
         tmo_cnt_q    <= tmo_cnt_d;
         flush_pend_q <= flush_pend_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         busy_q       <= busy_d;
         burst_cnt_q  <= burst_cnt_d;
      end
   end

endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 SHALL have parameter pDATA_WIDTH, default 8, FIFO/stream word width.
REQ-002 SHALL have parameter pBURST_LEN, default 16, max words per burst (range 1-255).
REQ-003 SHALL have ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- enable  in  1  permits new bursts to start.
- flush_req  in  1  one-cycle pulse requesting drain of residual data.
- timeout_cycles  in  16  idle-with-data timeout; 0 disables.
- fifo_empty  in  1  from non-fallthrough sync FIFO.
- fifo_almost_empty  in  1  FIFO holds at most 1 word.
- fifo_full_threshold  in  1  FIFO at or above programmed threshold.
- fifo_rdata  in  pDATA_WIDTH  FIFO registered read data.
- fifo_ren  out  1  FIFO read strobe.
- out_data  out  pDATA_WIDTH  stream data.
- out_valid  out  1  stream valid.
- out_last  out  1  final word of burst.
- out_ready  in  1  downstream accept.
- busy  out  1  high while not IDLE.
- burst_count  out  16  completed bursts, wraps at 65535->0.

Function
REQ-004 SHALL implement states IDLE, FULL_BURST, PART_BURST, DRAIN.
REQ-005 From IDLE with enable=1, SHALL enter FULL_BURST if fifo_full_threshold=1; else PART_BURST if flush pending and !fifo_empty; else PART_BURST on timeout expiry; priority in that order.
REQ-006 flush_req SHALL set a pending flag, cleared on entry to PART_BURST or when observed with fifo_empty=1 in IDLE.
REQ-007 Timeout counter SHALL be 0 in any cycle not (IDLE, enable=1, fifo_empty=0), increment otherwise, expiry when counter==timeout_cycles and timeout_cycles!=0 (i.e. on the timeout_cycles+1th qualifying cycle).
REQ-008 fifo_ren SHALL be combinational = (FULL_BURST or PART_BURST) and !fifo_empty and words_left!=0 and (!out_valid or out_ready).
REQ-009 out_data SHALL equal fifo_rdata combinationally; out_valid SHALL be registered, set the cycle after a fifo_ren, cleared after out_ready handshake with no new fifo_ren.
REQ-010 Read-to-valid latency SHALL be 1 cycle; sustained throughput 1 word/cycle with out_ready=1.
REQ-011 words_left (8-bit) SHALL load pBURST_LEN on burst entry, decrement on each fifo_ren.
REQ-012 out_last SHALL be registered alongside out_valid: set for the word read when words_left==1, or in PART_BURST when fifo_almost_empty=1 at the read.
REQ-013 After the read producing out_last, SHALL enter DRAIN; DRAIN->IDLE on out_valid&out_ready&out_last; burst_count increments on that handshake.
REQ-014 FULL_BURST with fifo_empty=1 SHALL stall (no fifo_ren, out_valid drops after pending handshake) until data arrives; SHALL not terminate early.
REQ-015 out_valid=1 with out_ready=0 SHALL hold out_data/out_last stable (no fifo_ren issued).
REQ-016 Deasserting enable mid-burst SHALL complete the current burst; only IDLE exits are gated.
REQ-017 fifo_ren SHALL never assert while fifo_empty=1 (no underflow).

Reset
REQ-018 rst_n=0 SHALL asynchronously force IDLE, out_valid=0, out_last=0, busy=0, burst_count=0, words_left=0, timeout counter=0, flush pending=0; fifo_ren=0 follows.
REQ-019 Reset mid-burst SHALL abandon the burst without a final out_last; FIFO contents are not touched by this block.

Verification
REQ-020 pBURST_LEN=4, threshold asserted with 6 words D0-D5, out_ready=1 -> 4 consecutive out_valid cycles D0-D3, out_last on D3, burst_count=1, D4/D5 remain.
REQ-021 Same, out_ready toggled 1,0,1,0 -> each word held while ready=0, no duplicate or lost word, fifo_ren count=4.
REQ-022 2 words in FIFO, threshold=0, flush_req pulse -> PART_BURST emits 2 words, out_last on 2nd, IDLE, burst_count+1.
REQ-023 timeout_cycles=10, 1 word written, no threshold -> burst starts on 11th idle cycle, single word with out_last=1; timeout_cycles=0 -> no burst after 1000 cycles.
REQ-024 FULL_BURST with FIFO empty after 2 of 4 words -> stall, no fifo_ren; writes resume -> words 3,4 delivered, out_last on 4th.
REQ-025 rst_n pulsed low mid-burst -> all outputs at reset values same cycle; subsequent threshold burst proceeds normally.
